// File: rtl/vec_pkg.sv
// Shared types and sizing helpers for the vector-op initiator slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vec_pkg;

  typedef logic [31:0] fp32_t;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    RUN,
    WAIT,
    DRAIN
  } vec_state_e;

  // Element index width; a single-element vector still needs one bit.
  function automatic int vec_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_result_serializer.sv
// Holds a captured result vector and streams it out element by element.
// Latency: first element valid the cycle after the capture pulse.
// Backpressure: out_ready_i low holds idx, data and last stable.
module vec_result_serializer
  import vec_pkg::*;
#(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture_i,
  input  fp32_t [N-1:0]   result_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output fp32_t           out_data_o,
  output logic            out_last_o,
  output logic            drain_done_o
);

  localparam int IW = vec_idx_w(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  fp32_t [N-1:0] buf_q, buf_d;
  logic          valid_q, valid_d;
  logic [IW-1:0] idx_q, idx_d;

  // Capture loads the buffer and restarts the index; each accepted beat advances it.
  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    if (capture_i) begin
      buf_d   = result_i;
      valid_d = 1'b1;
      idx_d   = '0;
    end else if (valid_q && out_ready_i) begin
      if (idx_q == IDX_LAST) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  // Buffer, valid flag and drain index registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      buf_q   <= buf_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  // Data and last are forced to zero outside a drain so idle outputs stay clean.
  assign out_valid_o  = valid_q;
  assign out_data_o   = valid_q ? buf_q[idx_q] : '0;
  assign out_last_o   = valid_q && (idx_q == IDX_LAST);
  assign drain_done_o = valid_q && out_ready_i && (idx_q == IDX_LAST);

endmodule

// File: rtl/vec_stream_initiator.sv
// Loads two operand vectors serially, launches a parallel vector op, streams the result back.
// Latency: 1 (RUN) + W (WAIT, W>=2) + 1 cycles from last operand accept to first out_valid.
// Backpressure: in_ready low outside LOAD states; out_ready low stalls the drain in place.
module vec_stream_initiator
  import vec_pkg::*;
#(
  parameter int VECTOR_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  fp32_t                    in_data,
  output logic                     op_rst,
  output fp32_t [VECTOR_LEN-1:0]   op_vec1,
  output fp32_t [VECTOR_LEN-1:0]   op_vec2,
  input  fp32_t [VECTOR_LEN-1:0]   op_result,
  input  logic                     op_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output fp32_t                    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = vec_idx_w(VECTOR_LEN);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(VECTOR_LEN - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  vec_state_e              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;
  fp32_t [VECTOR_LEN-1:0]  vec1_q, vec2_q;
  logic                    wr_a, wr_b, capture, drain_done;

  // Next-state logic; cnt_q holds the number of WAIT cycles already completed.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    capture   = 1'b0;
    in_ready  = 1'b0;
    op_rst    = 1'b1;
    case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_a = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = LOAD_B;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_b = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      RUN: begin
        op_rst  = 1'b0;
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        op_rst = 1'b0;
        cnt_d  = cnt_q + CW'(1);
        // A done seen on the first WAIT cycle may be left over from the previous op.
        if (op_done && (cnt_q != '0)) begin
          capture = 1'b1;
          state_d = DRAIN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = LOAD_A;
          cnt_d     = '0;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = LOAD_A;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, load index, wait counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= LOAD_A;
      idx_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Operand registers; only written during their LOAD state, so they hold through RUN/WAIT/DRAIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec1_q <= '0;
      vec2_q <= '0;
    end else begin
      if (wr_a) vec1_q[idx_q] <= in_data;
      if (wr_b) vec2_q[idx_q] <= in_data;
    end
  end

  vec_result_serializer #(
    .N (VECTOR_LEN)
  ) u_ser (
    .clk          (clk),
    .rst          (rst),
    .capture_i    (capture),
    .result_i     (op_result),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .drain_done_o (drain_done)
  );

  assign op_vec1 = vec1_q;
  assign op_vec2 = vec2_q;
  assign busy    = !((state_q == LOAD_A) && (idx_q == '0));
  assign timeout = timeout_q;

endmodule

// File: tb/tb_vec_stream_initiator.sv
// Directed and randomized bench for vec_stream_initiator with a stub vector-op responder.
// Latency: checks first out_valid at cycle 1 + W + 1 after the last operand accept.
// Backpressure: random in_valid gaps and out_ready stalls exercise both handshakes.
module tb_vec_stream_initiator;
  import vec_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  localparam logic [31:0] ONE   = 32'h3F800000;
  localparam logic [31:0] TWO   = 32'h40000000;
  localparam logic [31:0] THREE = 32'h40400000;
  localparam logic [31:0] HALF  = 32'h3F000000;
  localparam logic [31:0] ONEP5 = 32'h3FC00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic          in_ready;
  fp32_t         in_data;
  logic          op_rst;
  fp32_t [N-1:0] op_vec1, op_vec2, op_result;
  logic          op_done;
  logic          out_valid;
  logic          out_ready;
  fp32_t         out_data;
  logic          out_last;
  logic          busy;
  logic          timeout;

  int total = 0;
  int bad   = 0;

  // Stub responder: 0 = done after resp_delay run cycles, 1 = never done, 2 = done held high.
  int resp_mode  = 0;
  int resp_delay = 3;
  int rcnt       = 0;

  vec_stream_initiator #(
    .VECTOR_LEN     (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .op_rst    (op_rst),
    .op_vec1   (op_vec1),
    .op_vec2   (op_vec2),
    .op_result (op_result),
    .op_done   (op_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .timeout   (timeout)
  );

  // Element-wise op: exact FP32 products for the values the directed cases use,
  // an asymmetric bit mix otherwise so swapped or misplaced operands are visible.
  function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b);
    if (a == ONE && b == ONE) return ONE;
    if ((a == ONE && b == TWO) || (a == TWO && b == ONE)) return TWO;
    if ((a == THREE && b == HALF) || (a == HALF && b == THREE)) return ONEP5;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0001;
  endfunction

  // Responder run-cycle counter, held at zero while the initiator keeps it in reset.
  always @(posedge clk) rcnt <= op_rst ? 0 : rcnt + 1;

  // Responder outputs.
  always_comb begin
    for (int i = 0; i < N; i++) op_result[i] = fres(op_vec1[i], op_vec2[i]);
    if (resp_mode == 2)      op_done = 1'b1;
    else if (resp_mode == 1) op_done = 1'b0;
    else                     op_done = !op_rst && (rcnt >= resp_delay);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    check({p, "_in_ready"},  32'(in_ready),  32'd1);
    check({p, "_op_rst"},    32'(op_rst),    32'd1);
    check({p, "_out_valid"}, 32'(out_valid), 32'd0);
    check({p, "_out_data"},  out_data,       32'd0);
    check({p, "_out_last"},  32'(out_last),  32'd0);
    check({p, "_busy"},      32'(busy),      32'd0);
    check({p, "_timeout"},   32'(timeout),   32'd0);
    for (int i = 0; i < N; i++) begin
      check({p, "_vec1"}, op_vec1[i], 32'd0);
      check({p, "_vec2"}, op_vec2[i], 32'd0);
    end
  endtask

  // Offer nbeats operand elements (vec1 then vec2) with random gaps; returns just after the last accept edge.
  task automatic send(input logic [31:0] a[N], input logic [31:0] b[N], input int nbeats, input int gap);
    int  sent   = 0;
    int  budget = 0;
    logic acc;
    while (sent < nbeats && budget < 500) begin
      in_valid = ($urandom_range(99) < gap) ? 1'b0 : 1'b1;
      in_data  = in_valid ? ((sent < N) ? a[sent] : b[sent - N]) : $urandom;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      budget++;
    end
    in_valid = 1'b0;
    in_data  = $urandom;
    if (budget >= 500) check("send_budget", sent, nbeats);
  endtask

  // Drain the result stream from just after the last operand accept and compare against the model.
  task automatic collect(input logic [31:0] a[N], input logic [31:0] b[N], input int w, input int bp);
    int   n     = 0;
    int   edges = 0;
    logic seen  = 1'b0;
    logic hs;
    while (n < N && edges < 300) begin
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("latency", edges + 1, w + 2);
          check("drain_op_rst", 32'(op_rst), 32'd1);
          check("drain_busy", 32'(busy), 32'd1);
          for (int i = 0; i < N; i++) begin
            check("op_vec1", op_vec1[i], a[i]);
            check("op_vec2", op_vec2[i], b[i]);
          end
        end
        check("out_data", out_data, fres(a[n], b[n]));
        check("out_last", 32'(out_last), (n == N - 1) ? 32'd1 : 32'd0);
        out_ready = ($urandom_range(99) >= bp) ? 1'b1 : 1'b0;
      end else begin
        out_ready = $urandom_range(1) != 0;
      end
      in_valid = 1'b1;
      in_data  = $urandom;
      hs = out_valid && out_ready;
      @(posedge clk);
      #1;
      edges++;
      if (hs) n++;
      in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("beats", n, N);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_op_rst", 32'(op_rst), 32'd1);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
  endtask

  logic [31:0] va[N], vb[N], vc[N], vd[N];
  int d;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk_reset("reset");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Directed product: {1,1,1,1} x {2,1,1,1}.
    va = '{ONE, ONE, ONE, ONE};
    vb = '{TWO, ONE, ONE, ONE};
    resp_mode  = 0;
    resp_delay = 3;
    send(va, vb, 2 * N, 0);
    check("dir_beat0_model", fres(va[0], vb[0]), TWO);
    collect(va, vb, 3, 0);

    // Same vectors with input gaps and output backpressure.
    for (int t = 0; t < 2; t++) begin
      d = $urandom_range(5);
      resp_delay = d;
      send(va, vb, 2 * N, 50);
      collect(va, vb, (d < 2) ? 2 : d, 50);
    end

    // Back-to-back follow-up {3.0} x {0.5}.
    vc = '{THREE, THREE, THREE, THREE};
    vd = '{HALF, HALF, HALF, HALF};
    resp_delay = 2;
    send(vc, vd, 2 * N, 0);
    collect(vc, vd, 2, 0);

    // Done held high: must not be taken on the first WAIT cycle.
    resp_mode = 2;
    send(vc, vd, 2 * N, 0);
    collect(vc, vd, 2, 0);

    // Random operands, delays, gaps and stalls.
    resp_mode = 0;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        vc[i] = $urandom;
        vd[i] = $urandom;
      end
      d = $urandom_range(6);
      resp_delay = d;
      send(vc, vd, 2 * N, 30);
      collect(vc, vd, (d < 2) ? 2 : d, 40);
    end

    // Responder never finishes: abort after exactly TO WAIT cycles.
    resp_mode = 1;
    send(va, vb, 2 * N, 0);
    for (int k = 1; k <= TO + 2; k++) begin
      tick();
      check("to_no_valid", 32'(out_valid), 32'd0);
      if (k == 1) check("to_wait_op_rst", 32'(op_rst), 32'd0);
      if (k == TO) check("to_not_yet", 32'(timeout), 32'd0);
      if (k == TO + 1) begin
        check("to_set", 32'(timeout), 32'd1);
        check("to_in_ready", 32'(in_ready), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_op_rst", 32'(op_rst), 32'd1);
      end
    end

    // Asynchronous reset in the middle of LOAD_B.
    resp_mode  = 0;
    resp_delay = 3;
    send(va, vb, N + 2, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("rst_loadb");
    #3;
    rst = 1'b1;
    tick();
    send(va, vb, 2 * N, 0);
    collect(va, vb, 3, 0);

    // Asynchronous reset in the middle of DRAIN.
    vc = '{THREE, HALF, ONE, TWO};
    vd = '{HALF, THREE, TWO, ONE};
    send(vc, vd, 2 * N, 0);
    for (int k = 0; k < 50 && !out_valid; k++) tick();
    check("drain_reached", 32'(out_valid), 32'd1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk_reset("rst_drain");
    #3;
    rst = 1'b1;
    tick();
    send(va, vb, 2 * N, 20);
    collect(va, vb, 3, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_stream_initiator.md
# vec_stream_initiator

Initiator side of the `vec_vec_to_vec` interface. Accepts two FP32 operand vectors element-serially over a valid/ready stream and presents them in parallel to a vector-op responder such as `vec_hadamard_product`. It launches the op, waits for `done`, captures the result vector and returns it element-serially on an output stream. It sits between the element-serial datapath (memory and layer sequencer) and every parallel vector-op block.

## Interface
Parameters:
- `VECTOR_LEN`, 4 — elements per vector, ≥1
- `TIMEOUT_CYCLES`, 1024 — maximum WAIT cycles before abort, ≥2

Ports:
- `clk`  in  1  — single clock
- `rst`  in  1  — asynchronous, active-low reset
- `in_valid`  in  1  — operand element valid
- `in_ready`  out  1  — initiator accepts element
- `in_data`  in  32  — FP32 bits; first VECTOR_LEN beats → vec1[0..N-1], next VECTOR_LEN → vec2[0..N-1]
- `op_rst`  out  1  — drives responder `rst`, active-high
- `op_vec1`, `op_vec2`  out  VECTOR_LEN×32  — operand registers to responder
- `op_result`  in  VECTOR_LEN×32  — responder result
- `op_done`  in  1  — responder completion
- `out_valid`  out  1  — result element valid
- `out_ready`  in  1  — consumer accepts element
- `out_data`  out  32  — result[idx] FP32 bits
- `out_last`  out  1  — high with result[VECTOR_LEN-1]
- `busy`  out  1  — high in any state except LOAD_A with idx=0
- `timeout`  out  1  — sticky abort flag, cleared only by reset

## Operation
- FSM states: LOAD_A → LOAD_B → RUN → WAIT → DRAIN → LOAD_A.
- Element index `idx`: $clog2(VECTOR_LEN)-bit, minimum 1 bit. Shared by LOAD_A, LOAD_B and DRAIN. Cleared on every state change.
- LOAD_A and LOAD_B:
  - `in_ready`=1.
  - On `in_valid&&in_ready`, write `in_data` to vec1[idx] or vec2[idx] and increment idx.
  - On the beat with idx=N-1, advance state.
- RUN (1 cycle): `op_rst`=0, `in_ready`=0.
- WAIT:
  - `op_rst`=0.
  - `op_done` is ignored on the first WAIT cycle (guard against stale done).
  - From the second cycle on, `op_done`=1 → capture `op_result` into the result buffer, then enter DRAIN.
  - Wait counter reaching TIMEOUT_CYCLES → set `timeout`, discard the result, return to LOAD_A.
- `op_rst`=1 in LOAD_A, LOAD_B and DRAIN, so the responder stays held between ops.
- DRAIN:
  - `out_valid`=1, `out_data`=buffer[idx].
  - `out_last` = (idx==N-1).
  - On `out_ready`, increment idx; on the last beat go to LOAD_A.
- `op_vec1` and `op_vec2` are stable from the end of LOAD_B until the next LOAD_A write.
- No arithmetic on data; bits pass through unmodified, so NaN and denormal patterns are preserved.

## Timing
- Reset values: `in_ready`=1, `op_rst`=1, `op_vec1`/`op_vec2`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `timeout`=0; state LOAD_A, idx=0.
- Reset asserted mid-operation: all of the above takes effect immediately, regardless of clock. Any partial load or result is lost.
- Input throughput: 1 element/cycle; 2N cycles minimum to load.
- Latency from last operand accept to first `out_valid`: 1 (RUN) + W + 1 cycles, where W ≥ 2 is the number of WAIT cycles up to and including the `op_done` sample.
- Output throughput: 1 element/cycle while `out_ready`=1.
- Output stalls (`out_ready`=0): `out_data` and `out_last` are held stable.
- `in_valid` gaps: idx holds.
- `in_valid`=1 outside LOAD states: not accepted (`in_ready`=0), no side effects.
- `op_done` arriving in the same cycle the counter hits TIMEOUT_CYCLES: `op_done` wins and the result is captured.
- N=1: each LOAD state and DRAIN is exactly one beat, and `out_last` is high on that single beat.

## Structure
- Package `vec_pkg`:
  - `fp32_t` (logic[31:0])
  - `vec_state_e` enum {LOAD_A, LOAD_B, RUN, WAIT, DRAIN}
  - function `vec_idx_w(N)` returning max(1, $clog2(N))
- Sub-module `vec_result_serializer`: result buffer, idx and the out valid/ready handshake. Loaded by a capture pulse; reports drain-complete.
- Top level holds the FSM, operand registers and timeout counter.

## Test plan
- Load vec1={1,1,1,1} (0x3F800000 ×4) and vec2={2,1,1,1} (first 0x40000000) against `vec_hadamard_product` → out beats 0x40000000, 0x3F800000, 0x3F800000, 0x3F800000; `out_last` only on beat 3; `op_rst` high again after DRAIN.
- Random `in_valid` gaps and `out_ready` backpressure (50%) on the same vectors → identical output sequence; `out_data` stable during stalls; no beat duplicated or dropped.
- Stub responder that never asserts done, TIMEOUT_CYCLES=16 → `timeout`=1 exactly 16 cycles into WAIT, no `out_valid`, state back to LOAD_A, `in_ready`=1.
- Stub responder holding `op_done`=1 continuously → capture occurs on the second WAIT cycle, not the first.
- `rst` asserted low mid-LOAD_B and mid-DRAIN → all outputs take their reset values without waiting for a clock edge; a following full transaction produces the correct results.
- Back-to-back transactions with {3.0,…}×{0.5,…} following the first → second result 0x3FC00000 ×4; no residue from the first transaction.
